seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Receive-side checker for the periodic 5-bit pattern 11001, sent MSB first.
- Detects each occurrence of the pattern in a serial bit stream.
- Locks to the stream's 5-bit period after repeated correctly spaced detections.
- While locked, checks every bit against the expected pattern bit, counts errors and drops lock on sustained corruption.
- Sits at the far end of the serial link, downstream of the sequence generator.

Parameters:
- LOCK_CNT, 3: consecutive detections spaced exactly 5 valid bits apart required to lock.
- UNLOCK_CNT, 2: consecutive bad periods while locked that force return to hunt.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  qualifies din; all state advances only when din_valid=1.
- din  in  1  serial data bit.
- clr_err  in  1  synchronous clear of err_cnt.
- det  out  1  one-cycle pulse: pattern 11001 completed.
- locked  out  1  high while in LOCKED state.
- err  out  1  one-cycle pulse: bit mismatch while locked.
- err_cnt  out  ERR_W  saturating count of mismatched bits.

Behaviour:
- Reset: all outputs 0. Internal state: detector IDLE, lock FSM HUNT, all counters 0. Reset mid-stream aborts everything immediately; no partial match survives.
- Detector FSM (overlapping). States and transitions on valid bits:
  - IDLE: 1 -> G1, 0 -> IDLE.
  - G1: 1 -> G11, 0 -> IDLE.
  - G11: 1 -> G11, 0 -> G110.
  - G110: 0 -> G1100, 1 -> G1.
  - G1100: 1 -> DET, 0 -> IDLE.
  - DET: 1 -> G11, 0 -> IDLE.
- det: registered. Asserted exactly one clk after the valid bit that enters DET. Not repeated while din_valid=0.
- Spacing: number of valid bits from one completing bit to the next, inclusive of the second. Tracked by a 3-bit counter saturating at 7.
- Lock FSM, state HUNT:
  - On each detection: if spacing==5, match_run++; otherwise match_run=1. The first detection after reset or unlock gives match_run=1.
  - When match_run reaches LOCK_CNT, go to LOCKED. locked rises one clk after the completing bit.
  - Phase counter set to 0 for the next valid bit.
- Lock FSM, state LOCKED:
  - Phase counter runs 0..4 on valid bits and wraps.
  - Expected bit = PATTERN[4-phase], i.e. 1,1,0,0,1.
  - Mismatch: err pulses one clk later and err_cnt increments, saturating at all-ones.
  - On the phase-4 bit, evaluate the period. A period with any mismatch (including this bit) is bad: bad_run++. A clean period sets bad_run=0.
  - When bad_run reaches UNLOCK_CNT, return to HUNT. locked falls one clk after that bit. match_run, bad_run and spacing are cleared.
  - The detector keeps running in both states; det pulses are unaffected by lock state.
- clr_err: sets err_cnt=0 on the next edge. If it coincides with an increment, clear wins.
- din_valid=0: no state, counter or phase change. det and err stay low.

Optional Feature:
- Macro: SEQ_CHK_NONOVL_EN.
- Defined: non-overlapping detection. DET on 1 -> G1 (not G11); DET on 0 -> IDLE. Bits of a detected pattern are never reused.
- Undefined: overlapping transitions as listed in Behaviour.
- Lock and error logic are identical in both builds. A clean periodic stream locks the same way either way.

Decomposition:
- Package seq_chk_pkg holds:
  - detector state localparams (3-bit IDLE..DET);
  - lock state localparams (HUNT, LOCKED);
  - PATTERN=5'b11001;
  - PERIOD=5.
- Sub-module seq_det_fsm: detector FSM plus registered det pulse; ports clk, rst, din_valid, din, det.
- Top seq_checker instantiates seq_det_fsm and adds the spacing, lock, phase and error logic.

Test Plan:
- Reset, then 15 valid bits of 11001 repeated -> det pulses after bits 5, 10, 15; locked=1 one clk after bit 15; err_cnt=0.
- Stream 110011001 -> det after bits 5 and 9 (spacing 4, match_run stays 1). Built with SEQ_CHK_NONOVL_EN -> det after bit 5 only.
- Locked, flip one bit in one period, then clean -> single err pulse, err_cnt=1, locked stays 1. Two consecutive corrupted periods -> locked=0 after the 10th bit; a fresh 15 clean bits relock.
- din_valid toggled 1/0 every cycle on a clean stream -> same det and lock timing counted in valid bits; no events on idle cycles.
- err_cnt driven to 255 (ERR_W=8) -> holds 255. clr_err asserted together with a mismatch -> err_cnt=0.
- rst asserted mid-period while locked -> locked, det, err, err_cnt all 0 immediately; next 11001 gives det but not locked.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the 11001 sequence checker.
// Imported by seq_det_fsm and seq_checker.
package seq_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_G1    = 3'd1,
        S_G11   = 3'd2,
        S_G110  = 3'd3,
        S_G1100 = 3'd4,
        S_DET   = 3'd5
    } det_state_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam logic [4:0] PATTERN = 5'b11001;
    localparam int         PERIOD  = 5;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/seq_det_fsm.sv
// Overlapping 11001 detector with registered det pulse; hit is the same-cycle completion strobe.
// Build with SEQ_CHK_NONOVL_EN defined for non-overlapping detection.
module seq_det_fsm
    import seq_chk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din_valid,
    input  logic din,
    output logic hit,
    output logic det
);

    det_state_t state;
    det_state_t nxt;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = din ? S_G1    : S_IDLE;
            S_G1:    nxt = din ? S_G11   : S_IDLE;
            S_G11:   nxt = din ? S_G11   : S_G110;
            S_G110:  nxt = din ? S_G1    : S_G1100;
            S_G1100: nxt = din ? S_DET   : S_IDLE;
`ifdef SEQ_CHK_NONOVL_EN
            S_DET:   nxt = din ? S_G1    : S_IDLE;
`else
            S_DET:   nxt = din ? S_G11   : S_IDLE;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    assign hit = din_valid && (nxt == S_DET);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            det   <= 1'b0;
        end else begin
            det <= hit;
            if (din_valid) state <= nxt;
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Receive-side 11001 checker: detection, period lock, per-bit error check and counting.
// Optional SEQ_CHK_NONOVL_EN selects non-overlapping detection inside seq_det_fsm.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_err,
    output logic             det,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    lock_state_t   lock_state;
    logic          hit;
    logic [2:0]    spacing;
    logic          armed;
    logic [MW-1:0] match_run;
    logic [BW-1:0] bad_run;
    logic [2:0]    phase;
    logic          period_bad;

    logic [2:0]    spacing_next;
    logic [MW-1:0] run_next;
    logic [BW-1:0] bad_next;
    logic          mism;

    seq_det_fsm u_det (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .hit       (hit),
        .det       (det)
    );

    // armed marks that a previous completion exists to measure spacing from.
    assign spacing_next = sat_inc3(spacing);
    assign run_next     = (armed && spacing_next == 3'(PERIOD)) ? match_run + MW'(1) : MW'(1);
    assign bad_next     = bad_run + BW'(1);
    assign mism         = din != PATTERN[3'(PERIOD - 1) - phase];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= HUNT;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            spacing    <= '0;
            armed      <= 1'b0;
            match_run  <= '0;
            bad_run    <= '0;
            phase      <= '0;
            period_bad <= 1'b0;
        end else begin
            err <= 1'b0;
            if (din_valid) begin
                if (hit) begin
                    spacing <= '0;
                    armed   <= 1'b1;
                end else begin
                    spacing <= spacing_next;
                end
                case (lock_state)
                    HUNT: begin
                        if (hit) begin
                            match_run <= run_next;
                            if (run_next >= MW'(LOCK_CNT)) begin
                                lock_state <= LOCKED;
                                locked     <= 1'b1;
                                phase      <= '0;
                                period_bad <= 1'b0;
                                bad_run    <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (mism) begin
                            err <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (phase == 3'(PERIOD - 1)) begin
                            phase      <= '0;
                            period_bad <= 1'b0;
                            if (mism || period_bad) begin
                                if (bad_next >= BW'(UNLOCK_CNT)) begin
                                    lock_state <= HUNT;
                                    locked     <= 1'b0;
                                    match_run  <= '0;
                                    bad_run    <= '0;
                                    spacing    <= '0;
                                    armed      <= 1'b0;
                                end else begin
                                    bad_run <= bad_next;
                                end
                            end else begin
                                bad_run <= '0;
                            end
                        end else begin
                            phase      <= phase + 3'd1;
                            period_bad <= period_bad | mism;
                        end
                    end
                    default: lock_state <= HUNT;
                endcase
            end
            // Clear is placed last so it overrides a same-cycle increment.
            if (clr_err) err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: directed streams push expected events, a monitor pops them.
// Event indices count valid bits since the last reset (-2 marks the reset itself).
module tb_seq_checker;

    typedef enum int {EV_DET, EV_ERR, EV_UP, EV_DN} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       din_valid;
    logic       din;
    logic       clr_err;
    logic       det;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    ev_t  sb[$];
    int   total = 0;
    int   bad = 0;
    int   vec_idx = 0;
    int   cur_idx = -1;
    logic prev_locked = 1'b0;

    seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr_err   (clr_err),
        .det       (det),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int i);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got event at idx %0d expected none", k.name(), cur_idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s@%0d_kind", e.kind.name(), e.idx), int'(k), int'(e.kind));
            check($sformatf("%s@%0d_idx", e.kind.name(), e.idx), cur_idx, e.idx);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, after the bit of cur_idx was taken.
    always @(negedge clk) begin
        if (det) observe(EV_DET);
        if (err) observe(EV_ERR);
        if (locked !== prev_locked) observe(locked ? EV_UP : EV_DN);
        prev_locked = locked;
    end

    task automatic tick(input logic v, input logic b, input logic c);
        @(negedge clk);
        #1;
        din_valid = v;
        din       = b;
        clr_err   = c;
        if (v) begin
            vec_idx++;
            cur_idx = vec_idx;
        end else begin
            cur_idx = -1;
        end
    endtask

    task automatic send(input string s, input logic gap);
        logic b;
        for (int i = 0; i < s.len(); i++) begin
            b = (s[i] == 8'h31);
            tick(1'b1, b, 1'b0);
            if (gap) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic was_locked, input string tag);
        @(negedge clk);
        #1;
        if (was_locked) expect_ev(EV_DN, -2);
        rst       = 1'b1;
        din_valid = 1'b0;
        clr_err   = 1'b0;
        cur_idx   = -2;
        #1;
        check({tag, "_rst_det"}, int'(det), 0);
        check({tag, "_rst_err"}, int'(err), 0);
        check({tag, "_rst_locked"}, int'(locked), 0);
        check({tag, "_rst_err_cnt"}, int'(err_cnt), 0);
        @(negedge clk);
        #1;
        rst     = 1'b0;
        vec_idx = 0;
        cur_idx = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_err   = 1'b0;
        do_reset(1'b0, "init");

        // Overlap vs non-overlap: spacing 4 never builds a match run.
        expect_ev(EV_DET, 5);
`ifndef SEQ_CHK_NONOVL_EN
        expect_ev(EV_DET, 9);
`endif
        send("110011001", 1'b0);
        idle(1);
        check("ovl_locked", int'(locked), 0);
        do_reset(1'b0, "r1");

        // Clean lock: det at 5/10/15, lock on bit 15.
        expect_ev(EV_DET, 5);
        expect_ev(EV_DET, 10);
        expect_ev(EV_DET, 15);
        expect_ev(EV_UP, 15);
        send("110011100111001", 1'b0);
        idle(1);
        check("lock_locked", int'(locked), 1);
        check("lock_err_cnt", int'(err_cnt), 0);

        // One corrupted period between clean ones: single error, lock held.
        expect_ev(EV_DET, 20);
        expect_ev(EV_ERR, 23);
        expect_ev(EV_DET, 30);
        send("110011110111001", 1'b0);
        idle(1);
        check("one_bad_locked", int'(locked), 1);
        check("one_bad_err_cnt", int'(err_cnt), 1);

        // Two corrupted periods in a row drop lock on bit 40, then clean bits relock.
        expect_ev(EV_ERR, 33);
        expect_ev(EV_ERR, 38);
        expect_ev(EV_DN, 40);
        send("1110111101", 1'b0);
        idle(1);
        check("unlock_locked", int'(locked), 0);
        check("unlock_err_cnt", int'(err_cnt), 3);
        expect_ev(EV_DET, 45);
        expect_ev(EV_DET, 50);
        expect_ev(EV_DET, 55);
        expect_ev(EV_UP, 55);
        send("110011100111001", 1'b0);
        idle(1);
        check("relock_locked", int'(locked), 1);
        do_reset(1'b1, "r2");

        // Same stream with an idle cycle after every bit.
        expect_ev(EV_DET, 5);
        expect_ev(EV_DET, 10);
        expect_ev(EV_DET, 15);
        expect_ev(EV_UP, 15);
        send("110011100111001", 1'b1);
        idle(1);
        check("gap_locked", int'(locked), 1);
        do_reset(1'b1, "r3");

        // Saturation: lock, then alternate fully inverted and clean periods (5 errors each).
        expect_ev(EV_DET, 5);
        expect_ev(EV_DET, 10);
        expect_ev(EV_DET, 15);
        expect_ev(EV_UP, 15);
        send("110011100111001", 1'b0);
        for (int k = 0; k < 52; k++) begin
            for (int j = 0; j < 5; j++) expect_ev(EV_ERR, 16 + 10 * k + j);
            expect_ev(EV_DET, 25 + 10 * k);
            send("0011011001", 1'b0);
            if (k == 50) begin
                idle(1);
                check("sat_at_255", int'(err_cnt), 255);
            end
        end
        idle(1);
        check("sat_hold", int'(err_cnt), 255);
        check("sat_locked", int'(locked), 1);

        // clr_err on a mismatching bit: clear wins.
        expect_ev(EV_ERR, 536);
        tick(1'b1, 1'b0, 1'b1);
        send("1001", 1'b0);
        idle(1);
        check("clr_wins", int'(err_cnt), 0);
        check("clr_locked", int'(locked), 1);

        // Reset mid-period with a partial match pending; it must not survive.
        expect_ev(EV_ERR, 543);
        send("1110", 1'b0);
        idle(1);
        check("pre_rst_err_cnt", int'(err_cnt), 1);
        do_reset(1'b1, "r4");
        expect_ev(EV_DET, 7);
        send("0111001", 1'b0);
        idle(1);
        check("post_rst_locked", int'(locked), 0);

        idle(3);
        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
